// File: rtl/buffer_sequencer.sv
// rtl/buffer_sequencer.sv - pattern buffer field-pass / serial-load sequencer
// with a display-buffer select that defers swaps onto a buffer being rewritten.
module buffer_sequencer #(
  parameter int buffer_size  = 22,
  parameter int buffer_width = 8,
  parameter int no_bufs      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2:0]             buf_id,
  input  logic                   op_write,
  input  logic                   ser_req,
  input  logic [2:0]             ser_addr,
  input  logic [2:0]             disp_sel,
  input  logic                   disp_swap,
  output logic [no_bufs-1:0]     bufp,
  output logic [no_bufs-1:0]     buffer_select,
  output logic [buffer_size-1:0] fieldp,
  output logic [buffer_size-1:0] fieldwp,
  output logic                   field_write,
  output logic                   ssel,
  output logic [2:0]             saddr,
  output logic                   busy,
  output logic                   done,
  output logic                   start_rej
);

  typedef enum logic [2:0] {IDLE, PASS, WB, SER, DONE} state_t;

  localparam logic [4:0] last_idx = 5'(buffer_size - 1);
  localparam logic [7:0] ser_last = 8'(buffer_size * buffer_width - 1);

  state_t     state, state_nxt;
  logic [4:0] idx;
  logic [7:0] scnt;
  logic [2:0] buf_q;
  logic       wr_q;
  logic       pend;
  logic [2:0] pend_sel;
  logic       swap_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ser_req)    state_nxt = SER;
        else if (start) state_nxt = PASS;
      end
      PASS:    if (idx == last_idx) state_nxt = wr_q ? WB : DONE;
      WB:      state_nxt = DONE;
      SER:     if (scnt == ser_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Writes trail reads by one field; WB flushes the final field.
  always_comb begin
    fieldp      = '0;
    fieldwp     = '0;
    field_write = 1'b0;
    ssel        = 1'b0;
    busy        = (state != IDLE);
    done        = (state == DONE);
    case (state)
      PASS: begin
        fieldp = buffer_size'(1) << idx;
        if (wr_q && idx != 5'd0) begin
          fieldwp     = buffer_size'(1) << (idx - 5'd1);
          field_write = 1'b1;
        end
      end
      WB: begin
        fieldwp     = {1'b1, {(buffer_size-1){1'b0}}};
        field_write = 1'b1;
      end
      SER:     ssel = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      scnt      <= '0;
      buf_q     <= '0;
      wr_q      <= 1'b0;
      saddr     <= '0;
      bufp      <= no_bufs'(1);
      start_rej <= 1'b0;
    end else begin
      start_rej <= start && (state != IDLE || ser_req);
      case (state)
        IDLE: begin
          idx  <= '0;
          scnt <= '0;
          if (ser_req) begin
            saddr <= ser_addr;
          end else if (start) begin
            buf_q <= buf_id;
            wr_q  <= op_write;
            bufp  <= no_bufs'(1) << buf_id;
          end
        end
        PASS:    idx  <= idx + 5'd1;
        SER:     scnt <= scnt + 8'd1;
        default: ;
      endcase
    end
  end

  // Never show a buffer on the display while it is being rewritten.
  assign swap_hold = (state == PASS || state == WB) && wr_q && (disp_sel == buf_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buffer_select <= no_bufs'(1);
      pend          <= 1'b0;
      pend_sel      <= '0;
    end else if (disp_swap) begin
      if (swap_hold) begin
        pend     <= 1'b1;
        pend_sel <= disp_sel;
      end else begin
        buffer_select <= no_bufs'(1) << disp_sel;
        pend          <= 1'b0;
      end
    end else if (state == DONE && pend) begin
      buffer_select <= no_bufs'(1) << pend_sel;
      pend          <= 1'b0;
    end
  end

endmodule
